// File: rtl/regfile_wb_arbiter.sv
// Register-file write-back arbiter: LD, MD and ALU share one write port under
// fixed priority LD > MD > ALU, with promotion of requesters that wait too long.

module regfile_wb_starve_cnt #(
   parameter int STARVE_LIMIT = 4
) (
   input  logic clk,
   input  logic rst,
   input  logic valid,
   input  logic accept,
   output logic starved
);
   logic [3:0] cnt_q, cnt_d;

   always_comb begin
      cnt_d = cnt_q;
      if (!valid || accept)   cnt_d = 4'd0;
      else if (cnt_q != 4'hF) cnt_d = cnt_q + 4'd1;
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) cnt_q <= 4'd0;
      else      cnt_q <= cnt_d;
   end

   assign starved = valid && (cnt_q >= 4'(STARVE_LIMIT));
endmodule

module regfile_wb_arbiter #(
   parameter int DATA_W       = 32,
   parameter int ADDR_W       = 5,
   parameter int STARVE_LIMIT = 4
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              ld_valid,
   input  logic              md_valid,
   input  logic              alu_valid,
   input  logic [ADDR_W-1:0] ld_rd,
   input  logic [ADDR_W-1:0] md_rd,
   input  logic [ADDR_W-1:0] alu_rd,
   input  logic [DATA_W-1:0] ld_data,
   input  logic [DATA_W-1:0] md_data,
   input  logic [DATA_W-1:0] alu_data,
   output logic              ld_ready,
   output logic              md_ready,
   output logic              alu_ready,
   output logic [ADDR_W-1:0] rf_wr_address,
   output logic [DATA_W-1:0] rf_wr_data,
   output logic              rf_write_enable,
   output logic [1:0]        grant_id,
   output logic              wb_stall
);
   localparam int NUM_REQ = 3;
   localparam logic [NUM_REQ-1:0] REQ_ONE = {{(NUM_REQ-1){1'b0}}, 1'b1};

   logic [NUM_REQ-1:0]             vld, starved, cand, grant;
   logic [NUM_REQ-1:0][ADDR_W-1:0] rd;
   logic [NUM_REQ-1:0][DATA_W-1:0] data;
   logic [ADDR_W-1:0]              sel_rd;
   logic [DATA_W-1:0]              sel_data;
   logic [1:0]                     sel_id;

   logic              wr_en_q, wr_en_d;
   logic [1:0]        grant_id_q, grant_id_d;
   logic [ADDR_W-1:0] wr_addr_q, wr_addr_d;
   logic [DATA_W-1:0] wr_data_q, wr_data_d;

   assign vld  = {alu_valid, md_valid, ld_valid};
   assign rd   = {alu_rd, md_rd, ld_rd};
   assign data = {alu_data, md_data, ld_data};

   generate
      for (genvar i = 0; i < NUM_REQ; i++) begin : g_req
         regfile_wb_starve_cnt #(.STARVE_LIMIT(STARVE_LIMIT)) u_starve (
            .clk     (clk),
            .rst     (rst),
            .valid   (vld[i]),
            .accept  (grant[i]),
            .starved (starved[i])
         );
      end
   endgenerate

   // Starved requesters form the candidate set when any exist; the lowest
   // index wins within it, which is the base priority order.
   always_comb begin
      cand  = (|starved) ? starved : vld;
      grant = cand & (~cand + REQ_ONE);
      if (!rst) grant = '0;
   end

   always_comb begin
      sel_rd   = '0;
      sel_data = '0;
      sel_id   = 2'd3;
      for (int i = 0; i < NUM_REQ; i++) begin
         if (grant[i]) begin
            sel_rd   = rd[i];
            sel_data = data[i];
            sel_id   = 2'(i);
         end
      end
   end

   // Writes to r0 are consumed but never reach the register file.
   always_comb begin
      wr_en_d    = (|grant) && (sel_rd != '0);
      grant_id_d = wr_en_d ? sel_id : 2'd3;
      wr_addr_d  = wr_en_d ? sel_rd : wr_addr_q;
      wr_data_d  = wr_en_d ? sel_data : wr_data_q;
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         wr_en_q    <= 1'b0;
         grant_id_q <= 2'd3;
         wr_addr_q  <= '0;
         wr_data_q  <= '0;
      end else begin
         wr_en_q    <= wr_en_d;
         grant_id_q <= grant_id_d;
         wr_addr_q  <= wr_addr_d;
         wr_data_q  <= wr_data_d;
      end
   end

   assign ld_ready        = grant[0];
   assign md_ready        = grant[1];
   assign alu_ready       = grant[2];
   assign wb_stall        = |(vld & ~grant);
   assign rf_write_enable = wr_en_q;
   assign grant_id        = grant_id_q;
   assign rf_wr_address   = wr_addr_q;
   assign rf_wr_data      = wr_data_q;
endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// Bench for regfile_wb_arbiter: queued requesters, a cycle-level reference
// model checked every negedge, and directed literal checks.
module tb_regfile_wb_arbiter;
   localparam int DW  = 32;
   localparam int AW  = 5;
   localparam int LIM = 4;

   typedef struct {
      logic [AW-1:0] rd;
      logic [DW-1:0] d;
   } req_t;

   logic          clk = 1'b0;
   logic          rst = 1'b0;
   logic [2:0]    vld = '0;
   logic [AW-1:0] rd  [3] = '{default: '0};
   logic [DW-1:0] dat [3] = '{default: '0};
   logic          ld_ready, md_ready, alu_ready;
   logic [AW-1:0] rf_wr_address;
   logic [DW-1:0] rf_wr_data;
   logic          rf_write_enable;
   logic [1:0]    grant_id;
   logic          wb_stall;
   logic [2:0]    rdy;

   assign rdy = {alu_ready, md_ready, ld_ready};

   regfile_wb_arbiter #(.DATA_W(DW), .ADDR_W(AW), .STARVE_LIMIT(LIM)) dut (
      .clk(clk), .rst(rst),
      .ld_valid(vld[0]), .md_valid(vld[1]), .alu_valid(vld[2]),
      .ld_rd(rd[0]), .md_rd(rd[1]), .alu_rd(rd[2]),
      .ld_data(dat[0]), .md_data(dat[1]), .alu_data(dat[2]),
      .ld_ready(ld_ready), .md_ready(md_ready), .alu_ready(alu_ready),
      .rf_wr_address(rf_wr_address), .rf_wr_data(rf_wr_data),
      .rf_write_enable(rf_write_enable), .grant_id(grant_id), .wb_stall(wb_stall)
   );

   always #5 clk = ~clk;

   int n_chk = 0, n_fail = 0;
   int n_push = 0, n_acc = 0, max_wait = 0;

   function automatic void chk(string nm, logic [63:0] act, logic [63:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h, want 0x%0h", nm, act, exp);
      end
   endfunction

   // Pending requests per source; the driver presents the head and holds it until accepted.
   req_t       q [3][$];
   logic [2:0] acc = '0;

   task automatic push(int src, logic [AW-1:0] r, logic [DW-1:0] d);
      req_t t;
      t.rd = r;
      t.d  = d;
      q[src].push_back(t);
      n_push++;
   endtask

   initial forever begin
      @(posedge clk);
      #1;
      for (int i = 0; i < 3; i++) begin
         if (vld[i] && acc[i]) vld[i] = 1'b0;
         if (!vld[i] && q[i].size() != 0) begin
            rd[i]  = q[i][0].rd;
            dat[i] = q[i][0].d;
            void'(q[i].pop_front());
            vld[i] = 1'b1;
         end
      end
   end

   // Reference model: wait[i] is how many cycles source i has been left waiting.
   int            wt [3] = '{0, 0, 0};
   logic          m_wen  = 1'b0;
   logic [1:0]    m_gid  = 2'd3;
   logic [AW-1:0] m_addr = '0;
   logic [DW-1:0] m_data = '0;

   always @(negedge clk) begin : model
      int g, gs;
      logic [2:0] exp_rdy;
      if (!rst) begin
         chk("rst_ready", rdy, 3'b000);
         chk("rst_stall", wb_stall, |vld);
         chk("rst_wen", rf_write_enable, 1'b0);
         chk("rst_gid", grant_id, 2'd3);
         chk("rst_addr", rf_wr_address, '0);
         chk("rst_data", rf_wr_data, '0);
         wt     = '{0, 0, 0};
         m_wen  = 1'b0;
         m_gid  = 2'd3;
         m_addr = '0;
         m_data = '0;
         acc    = '0;
      end else begin
         chk("m_wen", rf_write_enable, m_wen);
         chk("m_gid", grant_id, m_gid);
         chk("m_addr", rf_wr_address, m_addr);
         chk("m_data", rf_wr_data, m_data);
         g  = 3;
         gs = 3;
         for (int i = 2; i >= 0; i--) begin
            if (vld[i]) g = i;
            if (vld[i] && wt[i] >= LIM) gs = i;
         end
         if (gs != 3) g = gs;
         exp_rdy = (g < 3) ? (3'b001 << g) : 3'b000;
         chk("m_ready", rdy, exp_rdy);
         chk("m_stall", wb_stall, |(vld & ~exp_rdy));
         if (g < 3) begin
            n_acc++;
            if (wt[g] > max_wait) max_wait = wt[g];
         end
         if (g < 3 && rd[g] != '0) begin
            m_wen  = 1'b1;
            m_gid  = 2'(g);
            m_addr = rd[g];
            m_data = dat[g];
         end else begin
            m_wen = 1'b0;
            m_gid = 2'd3;
         end
         for (int i = 0; i < 3; i++) wt[i] = (vld[i] && i != g) ? wt[i] + 1 : 0;
         acc = vld & rdy;
      end
   end

   task automatic drain();
      int k = 0;
      while ((q[0].size() + q[1].size() + q[2].size()) != 0 || vld != 3'b000) begin
         @(negedge clk);
         k++;
         if (k > 500) break;
      end
      chk("drain_bound", k <= 500, 1'b1);
      @(negedge clk);
   endtask

   initial begin : watchdog
      #1_000_000;
      $display("FAIL watchdog: got time limit, want finish");
      $fatal(1, "timeout");
   end

   initial begin : stim
      repeat (2) @(negedge clk);
      @(posedge clk);
      #2 rst = 1'b1;
      @(negedge clk);
      chk("init_gid", grant_id, 2'd3);
      chk("init_wen", rf_write_enable, 1'b0);

      // single ALU request
      push(2, 5'd5, 32'hDEAD_BEEF);
      @(negedge clk);
      chk("t1_alu_ready", rdy, 3'b100);
      chk("t1_stall", wb_stall, 1'b0);
      @(negedge clk);
      chk("t1_wen", rf_write_enable, 1'b1);
      chk("t1_addr", rf_wr_address, 5'd5);
      chk("t1_data", rf_wr_data, 32'hDEAD_BEEF);
      chk("t1_gid", grant_id, 2'd2);
      @(negedge clk);
      chk("t1_idle_wen", rf_write_enable, 1'b0);
      chk("t1_idle_addr", rf_wr_address, 5'd5);

      // three simultaneous requests: base priority order, no bubbles
      push(0, 5'd3, 32'hA1A1_0003);
      push(1, 5'd4, 32'hA1A1_0004);
      push(2, 5'd6, 32'hA1A1_0006);
      @(negedge clk);
      chk("t2_c1_ready", rdy, 3'b001);
      chk("t2_c1_stall", wb_stall, 1'b1);
      @(negedge clk);
      chk("t2_c2_ready", rdy, 3'b010);
      chk("t2_c2_stall", wb_stall, 1'b1);
      chk("t2_w1_addr", rf_wr_address, 5'd3);
      @(negedge clk);
      chk("t2_c3_ready", rdy, 3'b100);
      chk("t2_c3_stall", wb_stall, 1'b0);
      chk("t2_w2_addr", rf_wr_address, 5'd4);
      chk("t2_w2_gid", grant_id, 2'd1);
      @(negedge clk);
      chk("t2_w3_addr", rf_wr_address, 5'd6);
      chk("t2_w3_gid", grant_id, 2'd2);

      // write to r0 is consumed silently
      push(1, 5'd0, 32'h0000_1234);
      @(negedge clk);
      chk("t3_md_ready", rdy, 3'b010);
      @(negedge clk);
      chk("t3_wen", rf_write_enable, 1'b0);
      chk("t3_gid", grant_id, 2'd3);
      chk("t3_addr_hold", rf_wr_address, 5'd6);
      chk("t3_data_hold", rf_wr_data, 32'hA1A1_0006);

      // continuous LD traffic: ALU promoted on its 5th waiting cycle
      for (int i = 0; i < 8; i++) push(0, 5'(8 + i), 32'hB000_0000 + i);
      push(2, 5'd7, 32'h0000_0077);
      @(negedge clk);
      chk("t4_c1_ready", rdy, 3'b001);
      repeat (4) @(negedge clk);
      chk("t4_c5_ready", rdy, 3'b100);
      chk("t4_c5_stall", wb_stall, 1'b1);
      @(negedge clk);
      chk("t4_alu_gid", grant_id, 2'd2);
      chk("t4_alu_addr", rf_wr_address, 5'd7);
      chk("t4_c6_ready", rdy, 3'b001);
      drain();
      chk("t4_wait_reached", max_wait >= LIM, 1'b1);

      // reset pulse mid-stream with all three valid
      push(0, 5'd9, 32'hC000_0009);
      push(0, 5'd12, 32'hC000_000C);
      push(1, 5'd10, 32'hC000_000A);
      push(2, 5'd11, 32'hC000_000B);
      @(negedge clk);
      chk("t5_ld_first", rdy, 3'b001);
      @(posedge clk);
      #2 rst = 1'b0;
      #1;
      chk("t5_rst_wen", rf_write_enable, 1'b0);
      chk("t5_rst_gid", grant_id, 2'd3);
      chk("t5_rst_addr", rf_wr_address, '0);
      chk("t5_rst_data", rf_wr_data, '0);
      chk("t5_rst_ready", rdy, 3'b000);
      chk("t5_rst_stall", wb_stall, 1'b1);
      @(posedge clk);
      #2 rst = 1'b1;
      @(negedge clk);
      chk("t5_post_ld", rdy, 3'b001);
      chk("t5_post_wen", rf_write_enable, 1'b0);
      chk("t5_post_gid", grant_id, 2'd3);
      drain();

      // random saturating traffic
      for (int c = 0; c < 3000; c++) begin
         @(negedge clk);
         for (int i = 0; i < 3; i++)
            if (q[i].size() < 3 && $urandom_range(0, 99) < 40)
               push(i, 5'($urandom_range(0, 31)), $urandom);
      end
      drain();
      chk("max_wait_bound", max_wait <= LIM + 2, 1'b1);
      chk("accept_count", n_acc, n_push);

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end
endmodule
